// File: rtl/inst_queue.sv
// inst_queue: circular instruction buffer between fetch and decode (DEPTH entries).
// Latency: 1 cycle enqueue-to-output; 0 cycles when INST_QUEUE_BYPASS_EN is defined and the queue is empty.
// Backpressure: in_ready = !full (no pass-through into a full queue); head held stable while out_ready=0.
module inst_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [31:0]              in_inst,
  input  logic [63:0]              in_pc,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [31:0]              out_inst,
  output logic [63:0]              out_pc,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   inst_mem [DEPTH];
  logic [63:0]   pc_mem   [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          empty;
  logic          full;
  logic          byp;
  logic          enq;
  logic          deq;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[IW] != rd_ptr[IW]);

`ifdef INST_QUEUE_BYPASS_EN
  // Empty queue forwards the offered instruction straight to decode; gated by
  // rst_n so nothing is presented while reset is held.
  assign byp = rst_n && empty && in_valid && !flush;
`else
  assign byp = 1'b0;
`endif

  assign in_ready = !full;
  assign count    = wr_ptr - rd_ptr;

  // A bypassed instruction that decode takes this cycle is never written.
  assign enq = in_valid && !full && !flush && !(byp && out_ready);
  assign deq = !empty && out_ready && !flush;

  // Head presentation: stored head first, then bypass, otherwise NOP at pc 0.
  always_comb begin
    out_valid = !empty || byp;
    out_inst  = NOP;
    out_pc    = 64'h0;
    if (!empty) begin
      out_inst = inst_mem[rd_ptr[IW-1:0]];
      out_pc   = pc_mem[rd_ptr[IW-1:0]];
    end else if (byp) begin
      out_inst = in_inst;
      out_pc   = in_pc;
    end
  end

  // Pointer update; flush wins over any enqueue/dequeue in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  // Storage write; contents are don't-care after reset since pointers gate reads.
  always_ff @(posedge clk) begin
    if (enq) begin
      inst_mem[wr_ptr[IW-1:0]] <= in_inst;
      pc_mem[wr_ptr[IW-1:0]]   <= in_pc;
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: scripted table for fill/drain, hand sequences for wrap,
// flush, bypass and async reset, then randomized traffic against a queue model.
// Works for both builds; INST_QUEUE_BYPASS_EN changes the expected values.
module tb_inst_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef INST_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [63:0] in_pc;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_inst;
  logic [63:0] out_pc;
  logic        out_ready;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  inst_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc), .in_ready(in_ready),
    .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] inst;
    logic [63:0] pc;
    logic        ordy;
    logic        ev;
    logic [31:0] einst;
    logic [63:0] epc;
    logic [2:0]  ecnt;
    logic        erdy;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mk(input logic iv, input logic [31:0] inst, input logic [63:0] pc,
                              input logic ordy, input logic ev, input logic [31:0] einst,
                              input logic [63:0] epc, input logic [2:0] ecnt, input logic erdy);
    vec_t v;
    v.iv = iv; v.inst = inst; v.pc = pc; v.ordy = ordy;
    v.ev = ev; v.einst = einst; v.epc = epc; v.ecnt = ecnt; v.erdy = erdy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input logic ev, input logic [31:0] einst,
                         input logic [63:0] epc, input logic [2:0] ecnt, input logic erdy);
    chk({nm, ".out_valid"}, 64'(out_valid), 64'(ev));
    chk({nm, ".out_inst"},  64'(out_inst),  64'(einst));
    chk({nm, ".out_pc"},    out_pc,         epc);
    chk({nm, ".count"},     64'(count),     64'(ecnt));
    chk({nm, ".in_ready"},  64'(in_ready),  64'(erdy));
  endtask

  // Apply one cycle of inputs after the falling edge; outputs settle 1ns later.
  task automatic drive(input logic fl, input logic iv, input logic [31:0] inst,
                       input logic [63:0] pc, input logic ordy);
    @(negedge clk);
    flush = fl; in_valid = iv; in_inst = inst; in_pc = pc; out_ready = ordy;
    #1;
  endtask

  logic [95:0] q[$];

  initial begin
    logic [31:0] i0, i1, i2, i3, i4;
    i0 = 32'h00100093; i1 = 32'h00200113; i2 = 32'h00300193;
    i3 = 32'h00400213; i4 = 32'h00500293;

    // Fill to full with decode stalled, offer a fifth, then drain in order.
    tbl[0]  = mk(0, 0,  64'h0,           0, 0,   NOP, 64'h0, 0, 1);
    tbl[1]  = mk(1, i0, 64'h8000_0000,   0, BYP, BYP ? i0 : NOP,
                 BYP ? 64'h8000_0000 : 64'h0, 0, 1);
    tbl[2]  = mk(1, i1, 64'h8000_0004,   0, 1,   i0,  64'h8000_0000, 1, 1);
    tbl[3]  = mk(1, i2, 64'h8000_0008,   0, 1,   i0,  64'h8000_0000, 2, 1);
    tbl[4]  = mk(1, i3, 64'h8000_000C,   0, 1,   i0,  64'h8000_0000, 3, 1);
    tbl[5]  = mk(1, i4, 64'h8000_0010,   0, 1,   i0,  64'h8000_0000, 4, 0);
    tbl[6]  = mk(0, 0,  64'h0,           1, 1,   i0,  64'h8000_0000, 4, 0);
    tbl[7]  = mk(0, 0,  64'h0,           1, 1,   i1,  64'h8000_0004, 3, 1);
    tbl[8]  = mk(0, 0,  64'h0,           1, 1,   i2,  64'h8000_0008, 2, 1);
    tbl[9]  = mk(0, 0,  64'h0,           1, 1,   i3,  64'h8000_000C, 1, 1);
    tbl[10] = mk(0, 0,  64'h0,           0, 0,   NOP, 64'h0,         0, 1);

    rst_n = 1'b0; flush = 0; in_valid = 0; in_inst = 0; in_pc = 0; out_ready = 0;
    repeat (2) @(negedge clk);
    #1;
    chk_all("in_reset", 0, NOP, 64'h0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;

    drive(0, 0, 32'h0, 64'h0, 0);
    chk_all("after_reset", 0, NOP, 64'h0, 0, 1);

    for (int k = 0; k < 11; k++) begin
      drive(0, tbl[k].iv, tbl[k].inst, tbl[k].pc, tbl[k].ordy);
      chk_all($sformatf("tbl%0d", k), tbl[k].ev, tbl[k].einst, tbl[k].epc, tbl[k].ecnt, tbl[k].erdy);
    end

    // Ten back-to-back enqueues with decode ready: pointers wrap past 2*DEPTH.
    for (int k = 0; k < 10; k++) begin
      drive(0, 1, 32'h0000_0013 + 32'(k << 20), 64'h9000_0000 + 64'(4 * k), 1);
      if (BYP) begin
        chk_all($sformatf("wrap%0d", k), 1, 32'h0000_0013 + 32'(k << 20),
                64'h9000_0000 + 64'(4 * k), 0, 1);
      end else if (k == 0) begin
        chk_all("wrap0", 0, NOP, 64'h0, 0, 1);
      end else begin
        chk_all($sformatf("wrap%0d", k), 1, 32'h0000_0013 + 32'((k - 1) << 20),
                64'h9000_0000 + 64'(4 * (k - 1)), 1, 1);
      end
    end
    drive(0, 0, 32'h0, 64'h0, 1);
    if (BYP) chk_all("wrap_tail", 0, NOP, 64'h0, 0, 1);
    else     chk_all("wrap_tail", 1, 32'h0000_0013 + 32'(9 << 20), 64'h9000_0024, 1, 1);
    drive(0, 0, 32'h0, 64'h0, 0);
    chk_all("wrap_empty", 0, NOP, 64'h0, 0, 1);

    // Flush at count 3 with a concurrent offer: everything, including the offer, is dropped.
    for (int k = 0; k < 3; k++) drive(0, 1, 32'h0000_1013, 64'hA000_0000 + 64'(4 * k), 0);
    drive(1, 1, 32'h0000_2013, 64'hA000_0100, 1);
    chk("flush_pre.count", 64'(count), 64'd3);
    drive(0, 0, 32'h0, 64'h0, 0);
    chk_all("flush_post", 0, NOP, 64'h0, 0, 1);
    drive(0, 0, 32'h0, 64'h0, 0);
    chk_all("flush_post2", 0, NOP, 64'h0, 0, 1);

`ifdef INST_QUEUE_BYPASS_EN
    drive(0, 1, 32'h00a00093, 64'h8000_0040, 1);
    chk_all("bypass", 1, 32'h00a00093, 64'h8000_0040, 0, 1);
    drive(0, 0, 32'h0, 64'h0, 1);
    chk_all("bypass_after", 0, NOP, 64'h0, 0, 1);
`endif

    // Reset mid-operation clears the queue without a clock edge.
    drive(0, 1, 32'h0000_3013, 64'hB000_0000, 0);
    drive(0, 1, 32'h0000_4013, 64'hB000_0004, 0);
    drive(0, 0, 32'h0, 64'h0, 0);
    chk("areset_pre.count", 64'(count), 64'd2);
    #1 rst_n = 1'b0;
    #1 chk_all("areset", 0, NOP, 64'h0, 0, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic against a plain queue model.
    q.delete();
    for (int c = 0; c < 400; c++) begin
      logic fl, iv, ordy, emp, byp, ev;
      logic [31:0] inst, einst;
      logic [63:0] pc, epc;
      int sz;
      fl = ($urandom_range(15) == 0);
      iv = ($urandom_range(3) != 0);
      ordy = ($urandom_range(2) != 0);
      inst = $urandom;
      pc = {$urandom, $urandom};
      drive(fl, iv, inst, pc, ordy);
      sz = q.size();
      emp = (sz == 0);
      byp = BYP && emp && iv && !fl;
      ev = !emp || byp;
      einst = !emp ? q[0][95:64] : (byp ? inst : NOP);
      epc = !emp ? q[0][63:0] : (byp ? pc : 64'h0);
      chk_all($sformatf("rnd%0d", c), ev, einst, epc, 3'(sz), sz < DEPTH);
      if (fl) q.delete();
      else if (!(byp && ordy)) begin
        if (!emp && ordy) void'(q.pop_front());
        if (iv && sz < DEPTH) q.push_back({inst, pc});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4: number of entries; a power of two, at least 2.
REQ-002 The block SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-004 The block SHALL have port flush  input  1: discard all entries; parent drives it as clear | bj_en | trap_en.
REQ-005 The block SHALL have port in_valid  input  1: fetch offers an instruction.
REQ-006 The block SHALL have port in_inst  input  32: fetched instruction.
REQ-007 The block SHALL have port in_pc  input  64: pc of in_inst.
REQ-008 The block SHALL have port in_ready  output  1: queue accepts the offered instruction; equals !full.
REQ-009 The block SHALL have port out_valid  output  1: head entry is presented to decode.
REQ-010 The block SHALL have port out_inst  output  32: head instruction.
REQ-011 The block SHALL have port out_pc  output  64: head pc.
REQ-012 The block SHALL have port out_ready  input  1: decode consumes the head; parent drives it as !stall.
REQ-013 The block SHALL have port count  output  $clog2(DEPTH)+1: current number of stored entries.

Function
REQ-014 Enqueue SHALL occur on a rising edge where in_valid && in_ready && !flush; dequeue SHALL occur where out_valid && out_ready && !flush.
REQ-015 Storage SHALL be a circular buffer: read and write pointers are $clog2(DEPTH)+1 bits and wrap modulo 2*DEPTH; empty when the pointers are equal; full when the index bits are equal and the MSBs differ.
REQ-016 in_ready SHALL be 0 when full, even if a dequeue occurs in the same cycle; there is no enqueue-into-full pass-through.
REQ-017 Simultaneous enqueue and dequeue when not full and not empty SHALL leave count unchanged and preserve order.
REQ-018 out_valid SHALL be !empty; out_inst and out_pc SHALL be the head entry, read combinationally from storage.
REQ-019 When out_valid is 0, out_inst SHALL be 32'h0000_0013 (NOP) and out_pc SHALL be 64'h0.
REQ-020 A held head (out_valid && !out_ready) SHALL keep out_inst and out_pc stable until it is dequeued or flushed.
REQ-021 On flush, both pointers SHALL be set to 0 at the next edge; any enqueue or dequeue in the flush cycle SHALL be ignored; out_valid SHALL be 0 and count 0 in the following cycle.
REQ-022 Without bypass, enqueue-to-output latency SHALL be 1 cycle: an instruction written at edge N appears at the outputs after edge N.
REQ-023 count SHALL equal write pointer minus read pointer, in pointer width.

Reset
REQ-024 While rst_n=0: pointers SHALL be 0, count=0, out_valid=0, in_ready=1, out_inst=32'h0000_0013, out_pc=0.
REQ-025 Reset asserted mid-operation SHALL drop all entries immediately, without waiting for a clock edge; storage contents need not be cleared.

Configuration
REQ-026 Macro INST_QUEUE_BYPASS_EN SHALL select the bypass mode defined in REQ-027.
REQ-027 With the macro defined: when the queue is empty, in_valid=1 and flush=0, out_valid SHALL be 1 and out_inst/out_pc SHALL equal in_inst/in_pc in the same cycle; if out_ready=1 the entry is consumed without being written; if out_ready=0 it is written normally.
REQ-028 Without the macro, the REQ-022 latency SHALL apply and out_valid SHALL never depend combinationally on in_valid.

Verification
REQ-029 The bench SHALL cover: reset release, then in_valid=0 -> out_valid=0, out_inst=32'h00000013, in_ready=1, count=0.
REQ-030 The bench SHALL cover: enqueue pc 0x8000_0000, 0x8000_0004, 0x8000_0008, 0x8000_000C with out_ready=0 -> count=4, in_ready=0; the fifth offer is not accepted.
REQ-031 The bench SHALL cover: with the queue full, out_ready=1 for 4 cycles -> pcs emerge in order 0x8000_0000..0x8000_000C, count reaches 0, out_valid=0.
REQ-032 The bench SHALL cover: 10 continuous enqueues with out_ready=1 -> pointers wrap, order is preserved, count stays at most 1 (0 with bypass).
REQ-033 The bench SHALL cover: count=3 plus flush with in_valid=1 -> next cycle count=0, out_valid=0, and the offered instruction is dropped.
REQ-034 The bench SHALL cover, with INST_QUEUE_BYPASS_EN: queue empty, in_inst=32'h00a00093, out_ready=1 -> same-cycle out_inst=32'h00a00093, and count stays 0.
